// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/restoring_divider_sub_step.sv
// One (WIDTH+1)-bit trial subtraction; borrow is the MSB of the difference.
module sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  logic [WIDTH:0] full;

  assign full   = minuend_i - {1'b0, subtrahend_i};
  assign diff   = full[WIDTH-1:0];
  assign borrow = full[WIDTH];
endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per RUN cycle, WIDTH cycles per divide.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  sub_step #(.WIDTH(WIDTH)) u_step (
    .minuend_i   (shifted),
    .subtrahend_i(dsr_q),
    .diff        (trial),
    .borrow      (borrow)
  );

  // On borrow the shifted remainder is below the divisor, so its MSB is zero.
  assign step_rem = borrow ? shifted[WIDTH-1:0] : trial;
  assign step_quo = {dvd_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            res_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = dividend;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = step_quo;
          res_d   = step_rem;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: vector table, corner sequences, random vs arithmetic model.
module tb_restoring_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;

  int cyc   = 0;
  int nchk  = 0;
  int nfail = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, b,
                                output logic [W-1:0] q, r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issue one divide from an IDLE cycle, wait for done, check everything, step past DONE.
  task automatic run_check(input string nm, input logic [W-1:0] a, b, q, r,
                           input logic z, output int dcyc);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    dcyc = cyc;
    chk({nm, " latency"}, lat, (b == 0) ? 0 : W);
    chk({nm, " busy cycles"}, bcnt, (b == 0) ? 0 : W);
    chk({nm, " quotient"}, quotient, q);
    chk({nm, " remainder"}, remainder, r);
    chk({nm, " div_by_zero"}, div_by_zero, z);
    @(posedge clk); #1;
    chk({nm, " done one cycle"}, done, 0);
    chk({nm, " quotient held"}, quotient, q);
  endtask

  vec_t tbl[10];

  initial begin
    int d1, d2, n, acc;
    logic [W-1:0] a, b, q, r;
    logic z;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    rst = 1'b0;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
    tbl[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,  1'b0};
    tbl[2] = '{32'd3,          32'd10,         32'd0,          32'd3,  1'b0};
    tbl[3] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,  1'b1};
    tbl[4] = '{32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,  1'b0};
    tbl[5] = '{32'd7,          32'd7,          32'd1,          32'd0,  1'b0};
    tbl[6] = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0};
    tbl[7] = '{32'd1,          32'hFFFFFFFF,   32'd0,          32'd1,  1'b0};
    tbl[8] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,  1'b0};
    tbl[9] = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,  1'b0};
    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, d1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; acc = cyc;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("ignore start latency", cyc - acc, W);
    chk("ignore start quotient", quotient, 14);
    chk("ignore start remainder", remainder, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore start no new op", busy, 0);

    // reset mid-RUN after a div-by-zero result
    run_check("pre-reset 5/0", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, d1);
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrun rst quotient", quotient, 0);
    chk("midrun rst remainder", remainder, 0);
    chk("midrun rst busy", busy, 0);
    chk("midrun rst done", done, 0);
    chk("midrun rst div_by_zero", div_by_zero, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) n++;
    end
    chk("midrun rst no activity", n, 0);
    run_check("post-reset 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, d1);

    // back-to-back: start in the first IDLE cycle after DONE
    run_check("b2b first", 32'hDEADBEEF, 32'h10, 32'h0DEADBEE, 32'hF, 1'b0, d1);
    run_check("b2b second", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, d2);
    chk("b2b done spacing", d2 - d1, W + 2);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = $urandom;
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom_range(1, 1000);
      endcase
      model(a, b, q, r, z);
      run_check($sformatf("rand%0d", i), a, b, q, r, z, d1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
